// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions for the register-file slave.
//   axil_resp_t  : B-channel response encoding (OKAY / SLVERR)
//   axil_strb_w  : byte-strobe width for a given data width
package axil_pkg;

   typedef enum logic [1:0] {
      AXIL_OKAY   = 2'b00,
      AXIL_SLVERR = 2'b10
   } axil_resp_t;

   // Number of byte lanes (strobe bits) for a data bus of data_w bits.
   function automatic int unsigned axil_strb_w(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/axil_hold_reg.sv
// Single-entry valid/ready holding register.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : upstream valid
//   in_ready   : upstream ready (high while empty, driven from a flop only)
//   in_data    : upstream payload
//   data       : held payload
//   full       : entry occupied
//   clear      : consumer frees the entry (only meaningful while full)
module axil_hold_reg #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] data,
   output logic             full,
   input  logic             clear
);

   logic             full_q;
   logic [WIDTH-1:0] data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else if (clear) begin
         full_q <= 1'b0;
      end else if (in_valid && !full_q) begin
         full_q <= 1'b1;
         data_q <= in_data;
      end
   end

   assign in_ready = !full_q;
   assign full     = full_q;
   assign data     = data_q;

endmodule

// File: rtl/axil_slave_regfile_wr.sv
// AXI-Lite write-only register file slave.
//   aclk, aresetn    : clock, asynchronous active-low reset
//   s_axil_aw*       : write address channel (buffered in a single-entry hold)
//   s_axil_w*        : write data channel (buffered independently of AW)
//   s_axil_b*        : write response, OKAY for in-range words, SLVERR otherwise
//   reg_data         : registered contents of the NUMBER_REG words
//   reg_wr_pulse     : one-cycle pulse on the word written by a successful commit
module axil_slave_regfile_wr
   import axil_pkg::*;
#(
   parameter int unsigned                AXI_DATA_WIDTH = 32,
   parameter int unsigned                AXI_ADDR_WIDTH = 32,
   parameter int unsigned                NUMBER_REG     = 8,
   parameter logic [AXI_ADDR_WIDTH-1:0]  BASE_ADDR      = 32'h1000_0000,
   parameter logic [AXI_DATA_WIDTH-1:0]  RESET_VALUE    = '0
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic [AXI_ADDR_WIDTH-1:0]     s_axil_awaddr,
   input  logic                          s_axil_awvalid,
   output logic                          s_axil_awready,
   input  logic [AXI_DATA_WIDTH-1:0]     s_axil_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0]   s_axil_wstrb,
   input  logic                          s_axil_wvalid,
   output logic                          s_axil_wready,
   output logic [1:0]                    s_axil_bresp,
   output logic                          s_axil_bvalid,
   input  logic                          s_axil_bready,
   output logic [AXI_DATA_WIDTH-1:0]     reg_data [NUMBER_REG],
   output logic [NUMBER_REG-1:0]         reg_wr_pulse
);

   localparam int unsigned STRB_W     = axil_strb_w(AXI_DATA_WIDTH);
   localparam int unsigned BYTE_SHIFT = $clog2(STRB_W);

   logic                          aw_full;
   logic                          w_full;
   logic [AXI_ADDR_WIDTH-1:0]     aw_addr;
   logic [STRB_W+AXI_DATA_WIDTH-1:0] w_bundle;
   logic [AXI_DATA_WIDTH-1:0]     w_data;
   logic [STRB_W-1:0]             w_strb;

   logic                          commit;
   logic [AXI_ADDR_WIDTH-1:0]     off;
   logic [AXI_ADDR_WIDTH-1:0]     off_idx;
   logic                          legal;
   axil_resp_t                    result;

   logic                          bvalid_q;
   axil_resp_t                    bresp_q;
   logic [AXI_DATA_WIDTH-1:0]     reg_q [NUMBER_REG];
   logic [NUMBER_REG-1:0]         pulse_q;

   axil_hold_reg #(
      .WIDTH (AXI_ADDR_WIDTH)
   ) u_aw_hold (
      .clk      (aclk),
      .rst_n    (aresetn),
      .in_valid (s_axil_awvalid),
      .in_ready (s_axil_awready),
      .in_data  (s_axil_awaddr),
      .data     (aw_addr),
      .full     (aw_full),
      .clear    (commit)
   );

   axil_hold_reg #(
      .WIDTH (STRB_W + AXI_DATA_WIDTH)
   ) u_w_hold (
      .clk      (aclk),
      .rst_n    (aresetn),
      .in_valid (s_axil_wvalid),
      .in_ready (s_axil_wready),
      .in_data  ({s_axil_wstrb, s_axil_wdata}),
      .data     (w_bundle),
      .full     (w_full),
      .clear    (commit)
   );

   assign {w_strb, w_data} = w_bundle;

   // A pending response blocks the commit unless it is being accepted this cycle,
   // so a stalled B back-pressures both holds.
   assign commit = aw_full && w_full && (!bvalid_q || s_axil_bready);

   // Offset wraps modulo the address width; the explicit >= rejects addresses
   // below the base that would otherwise alias to a small index.
   assign off     = aw_addr - BASE_ADDR;
   assign off_idx = off >> BYTE_SHIFT;
   assign legal   = (aw_addr >= BASE_ADDR) && (off_idx < AXI_ADDR_WIDTH'(NUMBER_REG));
   assign result  = legal ? AXIL_OKAY : AXIL_SLVERR;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         bvalid_q <= 1'b0;
         bresp_q  <= AXIL_OKAY;
      end else if (commit) begin
         bvalid_q <= 1'b1;
         bresp_q  <= result;
      end else if (s_axil_bready) begin
         bvalid_q <= 1'b0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int unsigned i = 0; i < NUMBER_REG; i++) begin
            reg_q[i] <= RESET_VALUE;
         end
         pulse_q <= '0;
      end else begin
         pulse_q <= '0;
         if (commit && legal) begin
            for (int unsigned i = 0; i < NUMBER_REG; i++) begin
               if (off_idx == AXI_ADDR_WIDTH'(i)) begin
                  pulse_q[i] <= 1'b1;
                  for (int unsigned b = 0; b < STRB_W; b++) begin
                     if (w_strb[b]) begin
                        reg_q[i][8*b +: 8] <= w_data[8*b +: 8];
                     end
                  end
               end
            end
         end
      end
   end

   assign s_axil_bvalid = bvalid_q;
   assign s_axil_bresp  = bresp_q;
   assign reg_data      = reg_q;
   assign reg_wr_pulse  = pulse_q;

endmodule

// File: tb/tb_axil_slave_regfile_wr.sv
module tb_axil_slave_regfile_wr;

   logic        aclk;
   logic        aresetn;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] reg_data [8];
   logic [7:0]  reg_wr_pulse;

   int checks = 0;
   int errors = 0;

   axil_slave_regfile_wr #(
      .AXI_DATA_WIDTH (32),
      .AXI_ADDR_WIDTH (32),
      .NUMBER_REG     (8),
      .BASE_ADDR      (32'h1000_0000),
      .RESET_VALUE    (32'h0)
   ) dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .s_axil_awaddr  (awaddr),
      .s_axil_awvalid (awvalid),
      .s_axil_awready (awready),
      .s_axil_wdata   (wdata),
      .s_axil_wstrb   (wstrb),
      .s_axil_wvalid  (wvalid),
      .s_axil_wready  (wready),
      .s_axil_bresp   (bresp),
      .s_axil_bvalid  (bvalid),
      .s_axil_bready  (bready),
      .reg_data       (reg_data),
      .reg_wr_pulse   (reg_wr_pulse)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are sampled here.
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // Same-cycle AW+W; returns right after the commit edge with B visible.
   task automatic write_same(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      awaddr  = a;
      awvalid = 1'b1;
      wdata   = d;
      wstrb   = s;
      wvalid  = 1'b1;
      tick();
      awvalid = 1'b0;
      wvalid  = 1'b0;
      tick();
   endtask

   initial begin
      aresetn = 1'b0;
      awaddr  = '0;
      awvalid = 1'b0;
      wdata   = '0;
      wstrb   = '0;
      wvalid  = 1'b0;
      bready  = 1'b1;
      repeat (3) tick();
      aresetn = 1'b1;
      tick();

      // 1: reset state
      for (int i = 0; i < 8; i++) chk($sformatf("rst_reg%0d", i), 64'(reg_data[i]), 64'h0);
      chk("rst_bvalid", 64'(bvalid), 64'h0);
      chk("rst_awready", 64'(awready), 64'h1);
      chk("rst_wready", 64'(wready), 64'h1);
      chk("rst_pulse", 64'(reg_wr_pulse), 64'h0);

      // 2: same-cycle AW/W, one-cycle latency to B
      awaddr  = 32'h1000_0008;
      awvalid = 1'b1;
      wdata   = 32'hDEAD_BEEF;
      wstrb   = 4'hF;
      wvalid  = 1'b1;
      tick();
      awvalid = 1'b0;
      wvalid  = 1'b0;
      chk("t2_bvalid_early", 64'(bvalid), 64'h0);
      chk("t2_awready_held", 64'(awready), 64'h0);
      tick();
      chk("t2_bvalid", 64'(bvalid), 64'h1);
      chk("t2_bresp", 64'(bresp), 64'h0);
      chk("t2_reg2", 64'(reg_data[2]), 64'hDEAD_BEEF);
      chk("t2_pulse", 64'(reg_wr_pulse), 64'h04);
      tick();
      chk("t2_bvalid_clr", 64'(bvalid), 64'h0);
      chk("t2_pulse_clr", 64'(reg_wr_pulse), 64'h00);

      // 3: W first, AW three cycles later, partial strobes
      write_same(32'h1000_0000, 32'hFFFF_FFFF, 4'hF);
      chk("t3_pre_reg0", 64'(reg_data[0]), 64'hFFFF_FFFF);
      tick();
      wdata  = 32'h1122_3344;
      wstrb  = 4'b0101;
      wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      chk("t3_wready_held", 64'(wready), 64'h0);
      chk("t3_awready_free", 64'(awready), 64'h1);
      tick();
      tick();
      chk("t3_no_bvalid", 64'(bvalid), 64'h0);
      awaddr  = 32'h1000_0000;
      awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      tick();
      chk("t3_bvalid", 64'(bvalid), 64'h1);
      chk("t3_bresp", 64'(bresp), 64'h0);
      chk("t3_reg0", 64'(reg_data[0]), 64'hFF22_FF44);
      chk("t3_pulse", 64'(reg_wr_pulse), 64'h01);
      tick();

      // 4: out-of-range index and below-base address
      write_same(32'h1000_0020, 32'h1234_5678, 4'hF);
      chk("t4a_bresp", 64'(bresp), 64'h2);
      chk("t4a_pulse", 64'(reg_wr_pulse), 64'h0);
      chk("t4a_reg0", 64'(reg_data[0]), 64'hFF22_FF44);
      tick();
      write_same(32'h0FFF_FFFC, 32'h1234_5678, 4'hF);
      chk("t4b_bresp", 64'(bresp), 64'h2);
      chk("t4b_pulse", 64'(reg_wr_pulse), 64'h0);
      chk("t4b_reg2", 64'(reg_data[2]), 64'hDEAD_BEEF);
      chk("t4b_reg7", 64'(reg_data[7]), 64'h0);
      tick();

      // 4c: zero strobes on a legal word still pulses, data unchanged
      write_same(32'h1000_0008, 32'h0000_0000, 4'h0);
      chk("t4c_bresp", 64'(bresp), 64'h0);
      chk("t4c_pulse", 64'(reg_wr_pulse), 64'h04);
      chk("t4c_reg2", 64'(reg_data[2]), 64'hDEAD_BEEF);
      tick();

      // 5: B stalled, second write captured then holds close
      bready  = 1'b0;
      awaddr  = 32'h1000_0004;
      wdata   = 32'hAAAA_0001;
      wstrb   = 4'hF;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      tick();
      awaddr  = 32'h1000_000C;
      wdata   = 32'hBBBB_0002;
      tick();
      chk("t5_first_bvalid", 64'(bvalid), 64'h1);
      chk("t5_reg1", 64'(reg_data[1]), 64'hAAAA_0001);
      chk("t5_pulse1", 64'(reg_wr_pulse), 64'h02);
      chk("t5_awready_free", 64'(awready), 64'h1);
      tick();
      awvalid = 1'b0;
      wvalid  = 1'b0;
      chk("t5_awready_full", 64'(awready), 64'h0);
      chk("t5_wready_full", 64'(wready), 64'h0);
      repeat (8) tick();
      chk("t5_stall_bvalid", 64'(bvalid), 64'h1);
      chk("t5_stall_awready", 64'(awready), 64'h0);
      chk("t5_stall_reg3", 64'(reg_data[3]), 64'h0);
      chk("t5_stall_pulse", 64'(reg_wr_pulse), 64'h0);
      bready = 1'b1;
      tick();
      chk("t5_second_bvalid", 64'(bvalid), 64'h1);
      chk("t5_second_bresp", 64'(bresp), 64'h0);
      chk("t5_reg3", 64'(reg_data[3]), 64'hBBBB_0002);
      chk("t5_pulse3", 64'(reg_wr_pulse), 64'h08);
      chk("t5_awready_back", 64'(awready), 64'h1);
      tick();
      chk("t5_bvalid_clr", 64'(bvalid), 64'h0);

      // 6: reset with only AW held
      awaddr  = 32'h1000_0010;
      awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      chk("t6_aw_full", 64'(awready), 64'h0);
      chk("t6_w_empty", 64'(wready), 64'h1);
      aresetn = 1'b0;
      #2;
      chk("t6_async_awready", 64'(awready), 64'h1);
      chk("t6_async_reg3", 64'(reg_data[3]), 64'h0);
      tick();
      aresetn = 1'b1;
      tick();
      wdata  = 32'hCAFE_F00D;
      wstrb  = 4'hF;
      wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      tick();
      tick();
      chk("t6_no_bvalid", 64'(bvalid), 64'h0);
      chk("t6_reg4", 64'(reg_data[4]), 64'h0);
      chk("t6_reg0", 64'(reg_data[0]), 64'h0);
      chk("t6_pulse", 64'(reg_wr_pulse), 64'h0);
      chk("t6_awready", 64'(awready), 64'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
